serdes_job_scheduler: RTL and testbench

Controller that shares one bit-serial SERDES encryptor (start pulse, then 8 MSB-first `a_bit`/`b_bit` pairs, then `done` plus an 8-bit cipher) between two byte-parallel requesters. It round-robin arbitrates whole jobs, serialises the granted A/B bytes onto the encryptor, waits for completion with a timeout, and returns the cipher byte tagged with the requester ID. It sits between the host-side request logic and the encryptor core inside the top-level wrapper.

---
 rtl/serdes_pkg.sv | 17 +
 rtl/serdes_rr_arb.sv | 34 +++
 rtl/serdes_job_scheduler.sv | 134 +++++++++++++
 tb/tb_serdes_job_scheduler.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serdes_pkg.sv
// Shared definitions for the SERDES job scheduler: widths, requester count
// and FSM state encoding.
package serdes_pkg;

    localparam int BYTE_W  = 8;
    localparam int NUM_REQ = 2;
    localparam int IDX_W   = 3;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_START = 3'd1;
    localparam state_t ST_SHIFT = 3'd2;
    localparam state_t ST_WAIT  = 3'd3;
    localparam state_t ST_RESP  = 3'd4;

endpackage

// File: rtl/serdes_rr_arb.sv
// Two-way round-robin arbiter. A lone requester always wins; on a tie the
// pointer decides. The pointer moves to the loser only when a grant is issued.
module serdes_rr_arb
    import serdes_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_id
);

    logic ptr;

    // Pick the winner and decode it one-hot while enabled.
    always_comb begin
        gnt_id = (req == 2'b11) ? ptr : req[1];
        gnt    = '0;
        if (en && (|req)) begin
            gnt[gnt_id] = 1'b1;
        end
    end

    // Hand priority to the other requester after each grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (en && (|req)) begin
            ptr <= ~gnt_id;
        end
    end

endmodule

// File: rtl/serdes_job_scheduler.sv
// Shares one bit-serial encryptor between two byte-parallel requesters:
// arbitrates whole jobs, shifts A/B out MSB first, waits for done with a
// timeout and returns the cipher tagged with the requester id.
module serdes_job_scheduler
    import serdes_pkg::*;
#(
    parameter int TIMEOUT = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    input  logic [BYTE_W-1:0]  req0_a,
    input  logic [BYTE_W-1:0]  req0_b,
    input  logic [BYTE_W-1:0]  req1_a,
    input  logic [BYTE_W-1:0]  req1_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [BYTE_W-1:0]  rsp_cipher,
    output logic               rsp_err,
    output logic               enc_start,
    output logic               enc_a_bit,
    output logic               enc_b_bit,
    input  logic               enc_done,
    input  logic [BYTE_W-1:0]  enc_cipher,
    output logic               busy
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [7:0]         cnt;
    logic [BYTE_W-1:0]  a_q;
    logic [BYTE_W-1:0]  b_q;
    logic               id_q;
    logic [NUM_REQ-1:0] gnt;
    logic               gnt_id;

    // Requests are only considered while idle; the grant is the handshake.
    serdes_rr_arb u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_valid),
        .en     (state == ST_IDLE),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign req_ready = gnt;

    // Job FSM: grant, start pulse, 8 serial bits, wait/timeout, response hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            cnt        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= 1'b0;
            enc_start  <= 1'b0;
            enc_a_bit  <= 1'b0;
            enc_b_bit  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_cipher <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            enc_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|gnt) begin
                        a_q       <= gnt_id ? req1_a : req0_a;
                        b_q       <= gnt_id ? req1_b : req0_b;
                        id_q      <= gnt_id;
                        enc_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    idx       <= IDX_W'(7);
                    enc_a_bit <= a_q[7];
                    enc_b_bit <= b_q[7];
                    state     <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    // The output registers already hold bit idx; preload the next one.
                    if (idx == '0) begin
                        enc_a_bit <= 1'b0;
                        enc_b_bit <= 1'b0;
                        cnt       <= '0;
                        state     <= ST_WAIT;
                    end else begin
                        enc_a_bit <= a_q[idx - 3'd1];
                        enc_b_bit <= b_q[idx - 3'd1];
                        idx       <= idx - 3'd1;
                    end
                end
                ST_WAIT: begin
                    if (enc_done) begin
                        rsp_valid  <= 1'b1;
                        rsp_id     <= id_q;
                        rsp_cipher <= enc_cipher;
                        rsp_err    <= 1'b0;
                        state      <= ST_RESP;
                    end else if (cnt == TO_LAST) begin
                        rsp_valid  <= 1'b1;
                        rsp_id     <= id_q;
                        rsp_cipher <= '0;
                        rsp_err    <= 1'b1;
                        state      <= ST_RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serdes_job_scheduler.sv
// Self-checking bench for serdes_job_scheduler: a job-level timing model is
// compared against the DUT every cycle, with directed scenarios and a
// randomized phase, plus literal expectations for the directed cases.
module tb_serdes_job_scheduler;

    localparam int TIMEOUT = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_valid = 2'b00;
    logic [1:0] req_ready;
    logic [7:0] req0_a = 8'h00, req0_b = 8'h00, req1_a = 8'h00, req1_b = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic       rsp_id;
    logic [7:0] rsp_cipher;
    logic       rsp_err;
    logic       enc_start, enc_a_bit, enc_b_bit;
    logic       enc_done;
    logic [7:0] enc_cipher;
    logic       busy;

    logic       env_done = 1'b0;
    logic [7:0] env_cipher = 8'h00;
    logic       spur_done = 1'b0;
    logic [7:0] spur_cipher = 8'h00;
    int         enc_delay = 2;
    logic       rand_phase = 1'b0;

    assign enc_done   = env_done | spur_done;
    assign enc_cipher = spur_done ? spur_cipher : env_cipher;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serdes_job_scheduler #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_cipher(rsp_cipher), .rsp_err(rsp_err),
        .enc_start(enc_start), .enc_a_bit(enc_a_bit), .enc_b_bit(enc_b_bit),
        .enc_done(enc_done), .enc_cipher(enc_cipher), .busy(busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] grant_vec(input logic [1:0] v, input logic p);
        if (v == 2'b11) return p ? 2'b10 : 2'b01;
        return v;
    endfunction

    // Job-level model: where the current job started, when its response
    // begins, and what it carries.
    int         cyc = 0;
    logic       chk_en = 1'b0;
    logic       m_idle = 1'b1;
    logic       m_ptr = 1'b0;
    int         m_t = 0;
    int         m_rsp_from = -1;
    logic [7:0] m_a = 8'h00, m_b = 8'h00;
    logic       m_id = 1'b0;
    logic [7:0] m_cipher = 8'h00;
    logic       m_err = 1'b0;

    always @(posedge clk) begin
        int   c;
        logic g;
        c = cyc;
        if (rst) begin
            m_idle = 1'b1; m_ptr = 1'b0; m_rsp_from = -1; chk_en = 1'b1;
        end else if (m_idle) begin
            if (|req_valid) begin
                g = (grant_vec(req_valid, m_ptr) == 2'b10);
                m_t = c; m_id = g; m_ptr = !g;
                m_a = g ? req1_a : req0_a;
                m_b = g ? req1_b : req0_b;
                m_idle = 1'b0; m_rsp_from = -1;
            end
        end else if (m_rsp_from < 0) begin
            if (c >= m_t + 10) begin
                if (enc_done) begin
                    m_rsp_from = c + 1; m_cipher = enc_cipher; m_err = 1'b0;
                end else if (c == m_t + 10 + TIMEOUT - 1) begin
                    m_rsp_from = c + 1; m_cipher = 8'h00; m_err = 1'b1;
                end
            end
        end else if (rsp_ready && c >= m_rsp_from) begin
            m_idle = 1'b1;
        end
        cyc = cyc + 1;
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            int   off;
            logic ea, eb, ers;
            off = cyc - m_t;
            ea = 1'b0; eb = 1'b0;
            if (!m_idle && off >= 2 && off <= 9) begin
                ea = m_a[9-off];
                eb = m_b[9-off];
            end
            ers = !m_idle && m_rsp_from >= 0 && cyc >= m_rsp_from;
            chk("req_ready", req_ready, m_idle ? grant_vec(req_valid, m_ptr) : 2'b00);
            if (req_valid == 2'b11) chk("req_ready_onehot", ($countones(req_ready) <= 1), 1);
            chk("busy", busy, !m_idle);
            chk("enc_start", enc_start, (!m_idle && off == 1));
            chk("enc_a_bit", enc_a_bit, ea);
            chk("enc_b_bit", enc_b_bit, eb);
            chk("rsp_valid", rsp_valid, ers);
            if (ers) begin
                chk("rsp_id", rsp_id, m_id);
                chk("rsp_cipher", rsp_cipher, m_cipher);
                chk("rsp_err", rsp_err, m_err);
                if (rsp_ready && !m_err) chk("cipher_is_a_xor_b", rsp_cipher, m_a ^ m_b);
            end
        end
    end

    // Encryptor model: collect 8 serial bit pairs after start, answer A^B
    // with done high in the cycle that lies d cycles after bit 0.
    always begin
        logic [7:0] ea, eb;
        int d;
        @(negedge clk);
        if (chk_en && enc_start === 1'b1) begin
            ea = 8'h00; eb = 8'h00;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                ea = {ea[6:0], enc_a_bit};
                eb = {eb[6:0], enc_b_bit};
            end
            if (rand_phase) d = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(1, 36));
            else d = enc_delay;
            if (d >= 1) begin
                repeat (d) @(posedge clk);
                #1 env_done = 1'b1; env_cipher = ea ^ eb;
                @(posedge clk);
                #1 env_done = 1'b0; env_cipher = 8'h00;
            end
        end
    end

    task automatic wait_grant(output int t, output logic [1:0] g);
        t = -1; g = 2'b00;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin t = cyc; g = req_ready; break; end
        end
        if (t < 0) begin
            checks++; failures++;
            $display("FAIL wait_grant: no grant within 200 cycles");
        end
    endtask

    task automatic wait_rsp(output int t);
        t = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin t = cyc; break; end
        end
        if (t < 0) begin
            checks++; failures++;
            $display("FAIL wait_rsp: no response within 200 cycles");
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, c, r;
        logic [1:0] g;
        logic [7:0] sa, sb;

        // Reset and reset-state values.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_enc_start", enc_start, 0);

        // Single job, fast done.
        enc_delay = 2;
        @(posedge clk); #1 req_valid = 2'b01; req0_a = 8'h02; req0_b = 8'h03;
        wait_grant(t, g);
        chk("t1_grant", g, 2'b01);
        @(posedge clk); #1 req_valid = 2'b00;
        @(negedge clk);
        chk("t1_start_at_T1", enc_start, 1);
        sa = 8'h00; sb = 8'h00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sa = {sa[6:0], enc_a_bit};
            sb = {sb[6:0], enc_b_bit};
        end
        chk("t1_a_bits", sa, 8'h02);
        chk("t1_b_bits", sb, 8'h03);
        wait_rsp(c);
        chk("t1_rsp_latency", c - t, 12);
        chk("t1_rsp_id", rsp_id, 0);
        chk("t1_rsp_cipher", rsp_cipher, 8'h01);
        chk("t1_rsp_err", rsp_err, 0);

        // Contention from reset.
        do_reset();
        req0_a = 8'hC3; req0_b = 8'h5A; req1_a = 8'hA5; req1_b = 8'hFF;
        req_valid = 2'b11;
        wait_grant(t, g);
        chk("t2_first_grant", g, 2'b01);
        @(posedge clk); #1 req_valid = 2'b10;
        wait_rsp(c);
        chk("t2_first_id", rsp_id, 0);
        chk("t2_first_cipher", rsp_cipher, 8'h99);
        wait_grant(t, g);
        chk("t2_second_grant", g, 2'b10);
        @(posedge clk); #1 req_valid = 2'b00;
        wait_rsp(c);
        chk("t2_second_id", rsp_id, 1);
        chk("t2_second_cipher", rsp_cipher, 8'h5A);

        // Timeout, then a normal job.
        enc_delay = -1;
        @(posedge clk); #1 req_valid = 2'b01; req0_a = 8'h11; req0_b = 8'h22;
        wait_grant(t, g);
        @(posedge clk); #1 req_valid = 2'b00;
        wait_rsp(c);
        chk("t3_timeout_latency", c - t, 42);
        chk("t3_timeout_err", rsp_err, 1);
        chk("t3_timeout_cipher", rsp_cipher, 8'h00);
        enc_delay = 3;
        @(posedge clk); #1 req_valid = 2'b01; req0_a = 8'h6B; req0_b = 8'h0F;
        wait_grant(t, g);
        @(posedge clk); #1 req_valid = 2'b00;
        wait_rsp(c);
        chk("t3_after_err", rsp_err, 0);
        chk("t3_after_cipher", rsp_cipher, 8'h64);

        // Backpressure.
        @(posedge clk); #1 rsp_ready = 1'b0; req_valid = 2'b10; req1_a = 8'h3C; req1_b = 8'h0F;
        wait_grant(t, g);
        @(posedge clk); #1 req_valid = 2'b00;
        wait_rsp(c);
        @(posedge clk); #1 req_valid = 2'b01; req0_a = 8'h55; req0_b = 8'h0F;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", rsp_valid, 1);
            chk("t4_hold_cipher", rsp_cipher, 8'h33);
            chk("t4_hold_id", rsp_id, 1);
            chk("t4_no_ready", req_ready, 2'b00);
        end
        @(posedge clk); #1 rsp_ready = 1'b1; r = cyc;
        wait_grant(t, g);
        chk("t4_grant_after_release", t - r, 1);
        @(posedge clk); #1 req_valid = 2'b00;
        wait_rsp(c);
        chk("t4_next_cipher", rsp_cipher, 8'h5A);

        // Reset mid-SHIFT; requester 0 served so the pointer sits on 1.
        enc_delay = 2;
        @(posedge clk); #1 req_valid = 2'b01; req0_a = 8'hF0; req0_b = 8'h0F;
        wait_grant(t, g);
        @(posedge clk); #1 req_valid = 2'b00;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_busy", busy, 0);
        chk("t5_enc_start", enc_start, 0);
        chk("t5_a_bit", enc_a_bit, 0);
        chk("t5_b_bit", enc_b_bit, 0);
        chk("t5_rsp_valid", rsp_valid, 0);
        chk("t5_rsp_id", rsp_id, 0);
        chk("t5_rsp_cipher", rsp_cipher, 8'h00);
        chk("t5_rsp_err", rsp_err, 0);
        chk("t5_req_ready", req_ready, 2'b00);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("t5_no_response", rsp_valid, 0);
        end
        @(posedge clk); #1 req_valid = 2'b11; req0_a = 8'h81; req0_b = 8'h18; req1_a = 8'h00; req1_b = 8'h00;
        wait_grant(t, g);
        chk("t5_ptr_reset", g, 2'b01);
        @(posedge clk); #1 req_valid = 2'b00;
        wait_rsp(c);
        chk("t5_cipher", rsp_cipher, 8'h99);

        // Spurious done during SHIFT.
        @(posedge clk); #1 req_valid = 2'b10; req1_a = 8'hE7; req1_b = 8'h24;
        wait_grant(t, g);
        @(posedge clk); #1 req_valid = 2'b00;
        repeat (3) @(posedge clk);
        #1 spur_done = 1'b1; spur_cipher = 8'hEE;
        @(posedge clk); #1 spur_done = 1'b0; spur_cipher = 8'h00;
        wait_rsp(c);
        chk("t6_rsp_latency", c - t, 12);
        chk("t6_cipher", rsp_cipher, 8'hC3);
        chk("t6_err", rsp_err, 0);

        // Randomized traffic checked by the model.
        @(posedge clk); #1 rand_phase = 1'b1;
        repeat (600) begin
            @(posedge clk); #1;
            req_valid = 2'($urandom);
            req0_a = 8'($urandom); req0_b = 8'($urandom);
            req1_a = 8'($urandom); req1_b = 8'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1 req_valid = 2'b00; rsp_ready = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        chk("final_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
